// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the 2-read/1-write register file.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with set/clear and two post-update lookup ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] lk_addr_a,
  input  logic [AW-1:0] lk_addr_b,
  output logic          lk_busy_a,
  output logic          lk_busy_b
);
  logic [NREGS-1:ZERO_REG+1] busy, busy_nx;
  // Set wins over clear; register 0 and out-of-range addresses have no bit.
  for (genvar g = ZERO_REG + 1; g < NREGS; g++) begin : g_bit
    assign busy_nx[g] = (set_en && set_addr == AW'(g)) || (busy[g] && !(clr_en && clr_addr == AW'(g)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else busy <= busy_nx;
  end
  function automatic logic lookup(input logic [AW-1:0] addr);
    lookup = 1'b0;
    for (int i = ZERO_REG + 1; i < NREGS; i++)
      if (addr == AW'(i)) lookup = busy_nx[i];
  endfunction
  assign lk_busy_a = lookup(lk_addr_a);
  assign lk_busy_b = lookup(lk_addr_b);
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two registered read ports, one write port and a busy scoreboard.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en_a,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  output logic            rd_valid_a,
  output logic            rd_busy_a,
  input  logic            rd_en_b,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_b,
  output logic            rd_valid_b,
  output logic            rd_busy_b,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            busy_set_en,
  input  logic [AW-1:0]   busy_set_addr
);
  logic [XLEN-1:0] regs [ZERO_REG+1:NREGS-1];
  logic [1:0] en, lk;
  logic [AW-1:0] addr [2];
  assign en = {rd_en_b, rd_en_a};
  assign addr[0] = rd_addr_a;
  assign addr[1] = rd_addr_b;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = ZERO_REG + 1; i < NREGS; i++) regs[i] <= '0;
    else for (int i = ZERO_REG + 1; i < NREGS; i++) if (wr_en && wr_addr == AW'(i)) regs[i] <= wr_data;
  end
  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(busy_set_en),
    .set_addr(busy_set_addr),
    .clr_en(wr_en),
    .clr_addr(wr_addr),
    .lk_addr_a(addr[0]),
    .lk_addr_b(addr[1]),
    .lk_busy_a(lk[0]),
    .lk_busy_b(lk[1])
  );
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [XLEN-1:0] fwd, data;
    logic valid, busy;
    // Same-edge write to the read address is forwarded (write-first).
    always_comb begin
      fwd = '0;
      for (int i = ZERO_REG + 1; i < NREGS; i++)
        if (addr[p] == AW'(i)) fwd = (wr_en && wr_addr == addr[p]) ? wr_data : regs[i];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data <= '0;
        valid <= 1'b0;
        busy <= 1'b0;
      end else begin
        valid <= en[p];
        if (en[p]) begin
          data <= fwd;
          busy <= lk[p];
        end
      end
    end
  end
  assign rd_data_a = g_port[0].data;
  assign rd_valid_a = g_port[0].valid;
  assign rd_busy_a = g_port[0].busy;
  assign rd_data_b = g_port[1].data;
  assign rd_valid_b = g_port[1].valid;
  assign rd_busy_b = g_port[1].busy;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed self-checking bench for the default and a 24-register configuration.
module tb_regfile_2r1w;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rd_en_a, rd_en_b, wr_en, busy_set_en;
  logic [4:0] rd_addr_a, rd_addr_b, wr_addr, busy_set_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data_a, rd_data_b, rd_data_a24, rd_data_b24;
  logic rd_valid_a, rd_valid_b, rd_busy_a, rd_busy_b;
  logic rd_valid_a24, rd_valid_b24, rd_busy_a24, rd_busy_b24;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_2r1w dut (
    .clk(clk), .rst(rst),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a), .rd_busy_a(rd_busy_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr)
  );

  regfile_2r1w #(.NREGS(24)) dut24 (
    .clk(clk), .rst(rst),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a24), .rd_valid_a(rd_valid_a24), .rd_busy_a(rd_busy_a24),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b24), .rd_valid_b(rd_valid_b24), .rd_busy_b(rd_busy_b24),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en_a = 0; rd_en_b = 0; wr_en = 0; busy_set_en = 0;
  endtask

  initial begin
    idle();
    rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; busy_set_addr = 0; wr_data = 0;
    #1 rst = 1;
    #1;
    chk("rst_data_a", rd_data_a, 0);
    chk("rst_valid_a", {31'd0, rd_valid_a}, 0);
    chk("rst_busy_b", {31'd0, rd_busy_b}, 0);
    // Requests held during reset must be discarded
    rd_en_a = 1; wr_en = 1; wr_addr = 6; wr_data = 32'h6666;
    tick();
    chk("rst_hold_valid", {31'd0, rd_valid_a}, 0);
    @(negedge clk);
    rst = 0;
    idle();
    rd_en_a = 1; rd_addr_a = 6;
    tick();
    chk("rst_discard_wr", rd_data_a, 0);
    // Reset then read A=5, B=0
    rd_en_a = 1; rd_addr_a = 5; rd_en_b = 1; rd_addr_b = 0;
    tick();
    chk("r5_data_a", rd_data_a, 0);
    chk("r0_data_b", rd_data_b, 0);
    chk("r5_valid_a", {31'd0, rd_valid_a}, 1);
    chk("r0_valid_b", {31'd0, rd_valid_b}, 1);
    chk("r5_busy_a", {31'd0, rd_busy_a}, 0);
    idle();
    tick();
    chk("valid_pulse_a", {31'd0, rd_valid_a}, 0);
    chk("valid_pulse_b", {31'd0, rd_valid_b}, 0);
    // Write-first bypass on x7, then x0 stays zero
    wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF; rd_en_a = 1; rd_addr_a = 7;
    tick();
    chk("bypass_x7", rd_data_a, 32'hDEADBEEF);
    wr_addr = 0; wr_data = 32'h1234; rd_addr_a = 0;
    tick();
    chk("x0_zero", rd_data_a, 0);
    idle();
    rd_en_a = 1; rd_addr_a = 7;
    tick();
    chk("x7_stored", rd_data_a, 32'hDEADBEEF);
    idle();
    rd_addr_a = 0;
    tick();
    chk("hold_data_a", rd_data_a, 32'hDEADBEEF);
    chk("hold_valid_a", {31'd0, rd_valid_a}, 0);
    // Scoreboard
    busy_set_en = 1; busy_set_addr = 3;
    tick();
    idle();
    rd_en_a = 1; rd_addr_a = 3;
    tick();
    chk("busy_x3_set", {31'd0, rd_busy_a}, 1);
    wr_en = 1; wr_addr = 3; wr_data = 32'h33;
    tick();
    chk("busy_x3_clr", {31'd0, rd_busy_a}, 0);
    chk("data_x3", rd_data_a, 32'h33);
    busy_set_en = 1; busy_set_addr = 3; wr_data = 32'h34;
    tick();
    chk("busy_set_wins", {31'd0, rd_busy_a}, 1);
    idle();
    busy_set_en = 1; busy_set_addr = 0; rd_en_b = 1; rd_addr_b = 0;
    tick();
    chk("busy_x0_ignored", {31'd0, rd_busy_b}, 0);
    // Both ports on x9 while x9 is rewritten each cycle
    idle();
    rd_en_a = 1; rd_en_b = 1; rd_addr_a = 9; rd_addr_b = 9; wr_en = 1; wr_addr = 9;
    for (int k = 1; k <= 3; k++) begin
      wr_data = k;
      tick();
      chk("x9_a", rd_data_a, k);
      chk("x9_b", rd_data_b, k);
      chk("x9_valid", {30'd0, rd_valid_a, rd_valid_b}, 3);
    end
    // Reset mid-read
    idle();
    wr_en = 1; wr_addr = 4; wr_data = 32'h55; rd_en_a = 1; rd_addr_a = 4;
    tick();
    chk("x4_pre", rd_data_a, 32'h55);
    wr_en = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst_data", rd_data_a, 0);
    chk("mid_rst_valid", {31'd0, rd_valid_a}, 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("x4_post_rst", rd_data_a, 0);
    chk("x4_post_valid", {31'd0, rd_valid_a}, 1);
    // Out-of-range address on the 24-register instance
    idle();
    wr_en = 1; wr_addr = 23; wr_data = 32'hAB;
    tick();
    wr_addr = 1; wr_data = 32'h11;
    tick();
    wr_addr = 30; wr_data = 32'hFF; busy_set_en = 1; busy_set_addr = 30; rd_en_a = 1; rd_addr_a = 30;
    tick();
    chk("oor24_data", rd_data_a24, 0);
    chk("oor24_busy", {31'd0, rd_busy_a24}, 0);
    chk("oor24_valid", {31'd0, rd_valid_a24}, 1);
    chk("in32_x30", rd_data_a, 32'hFF);
    idle();
    rd_en_a = 1; rd_addr_a = 23; rd_en_b = 1; rd_addr_b = 1;
    tick();
    chk("r24_x23", rd_data_a24, 32'hAB);
    chk("r24_x1", rd_data_b24, 32'h11);
    rd_addr_a = 30; rd_addr_b = 9;
    tick();
    chk("r24_x30_again", rd_data_a24, 0);
    chk("r24_busy30", {31'd0, rd_busy_a24}, 0);
    chk("r32_busy30", {31'd0, rd_busy_a}, 1);
    chk("r24_x9_reset", rd_data_b24, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
